// File: rtl/sd_dma_reader.sv
// Read-direction SD DMA: fetches words from the cartridge memory bus and pushes them
// into the SD TX FIFO, holding back requests so reserved FIFO space covers every read in flight.
module sd_dma_reader #(
    parameter int MAX_INFLIGHT = 4,
    parameter int SPACE_W      = 11
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [3:0]         i_dma_bank,
    input  logic [23:0]        i_dma_address,
    input  logic [14:0]        i_dma_length,
    output logic [14:0]        o_dma_left,
    input  logic               i_dma_load_bank_address,
    input  logic               i_dma_load_length,
    input  logic               i_dma_start,
    input  logic               i_dma_stop,
    output logic               o_dma_busy,
    output logic               o_dma_error,
    output logic               o_tx_fifo_push,
    output logic [31:0]        o_tx_fifo_data,
    input  logic [SPACE_W-1:0] i_tx_fifo_space,
    output logic               o_request,
    output logic               o_write,
    input  logic               i_busy,
    input  logic               i_ack,
    output logic [3:0]         o_bank,
    output logic [23:0]        o_address,
    input  logic [31:0]        i_data,
    output logic [31:0]        o_data
);

    localparam int RW = SPACE_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    bank_q, bank_d;
    logic [23:0]   addr_q, addr_d;
    logic [14:0]   left_q, left_d;
    logic [3:0]    infl_q, infl_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          push_q, push_d;
    logic [31:0]   pdata_q, pdata_d;

    logic          accept;
    logic          ack_ok;
    logic [RW-1:0] reserved;

    // Space already promised: reads in flight plus the push currently on the FIFO port.
    assign reserved  = RW'(infl_q) + RW'(push_q);
    assign o_request = (state_q == S_ISSUE) && (left_q != 15'd0) &&
                       (infl_q < 4'(MAX_INFLIGHT)) &&
                       (RW'(i_tx_fifo_space) > reserved);
    assign accept    = o_request && !i_busy;
    assign ack_ok    = i_ack && (infl_q != 4'd0);

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        left_d  = left_q;
        busy_d  = busy_q;
        err_d   = err_q;
        push_d  = ack_ok;
        pdata_d = pdata_q;
        infl_d  = infl_q;

        if (ack_ok) begin
            pdata_d = i_data;
        end
        if (i_ack && !ack_ok) begin
            err_d = 1'b1;
        end

        case ({accept, ack_ok})
            2'b10:   infl_d = infl_q + 4'd1;
            2'b01:   infl_d = infl_q - 4'd1;
            default: infl_d = infl_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (i_dma_load_bank_address) begin
                    bank_d = i_dma_bank;
                    addr_d = i_dma_address;
                end
                if (i_dma_load_length) begin
                    left_d = i_dma_length;
                end
                if (i_dma_start && !i_dma_stop) begin
                    state_d = S_ISSUE;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                if (accept) begin
                    addr_d = addr_q + 24'd1;
                    left_d = left_q - 15'd1;
                end
                if ((left_q == 15'd0) || i_dma_stop) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // With nothing in flight the last push is already on the FIFO port and lands at this edge.
                if (infl_q == 4'd0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            bank_q  <= 4'd0;
            addr_q  <= 24'd0;
            left_q  <= 15'd0;
            infl_q  <= 4'd0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            push_q  <= 1'b0;
            pdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            infl_q  <= infl_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            push_q  <= push_d;
            pdata_q <= pdata_d;
        end
    end

    assign o_dma_left     = left_q;
    assign o_dma_busy     = busy_q;
    assign o_dma_error    = err_q;
    assign o_tx_fifo_push = push_q;
    assign o_tx_fifo_data = pdata_q;
    assign o_bank         = bank_q;
    assign o_address      = addr_q;
    assign o_write        = 1'b0;
    assign o_data         = 32'd0;

endmodule

// File: tb/tb_sd_dma_reader.sv
// Scoreboard bench for sd_dma_reader: a memory model answers accepted reads with
// data {4'hD, bank, address}; a monitor checks request addresses and FIFO pushes against queued expectations.
module tb_sd_dma_reader;

    localparam int MAXI = 4;
    localparam int SW   = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    i_dma_bank = '0;
    logic [23:0]   i_dma_address = '0;
    logic [14:0]   i_dma_length = '0;
    logic [14:0]   o_dma_left;
    logic          i_dma_load_bank_address = 1'b0;
    logic          i_dma_load_length = 1'b0;
    logic          i_dma_start = 1'b0;
    logic          i_dma_stop = 1'b0;
    logic          o_dma_busy;
    logic          o_dma_error;
    logic          o_tx_fifo_push;
    logic [31:0]   o_tx_fifo_data;
    logic [SW-1:0] i_tx_fifo_space = 11'd512;
    logic          o_request;
    logic          o_write;
    logic          i_busy = 1'b0;
    logic          i_ack = 1'b0;
    logic [3:0]    o_bank;
    logic [23:0]   o_address;
    logic [31:0]   i_data = '0;
    logic [31:0]   o_data;

    sd_dma_reader #(.MAX_INFLIGHT(MAXI), .SPACE_W(SW)) dut (
        .i_clk                   (clk),
        .i_reset_n               (rst_n),
        .i_dma_bank              (i_dma_bank),
        .i_dma_address           (i_dma_address),
        .i_dma_length            (i_dma_length),
        .o_dma_left              (o_dma_left),
        .i_dma_load_bank_address (i_dma_load_bank_address),
        .i_dma_load_length       (i_dma_load_length),
        .i_dma_start             (i_dma_start),
        .i_dma_stop              (i_dma_stop),
        .o_dma_busy              (o_dma_busy),
        .o_dma_error             (o_dma_error),
        .o_tx_fifo_push          (o_tx_fifo_push),
        .o_tx_fifo_data          (o_tx_fifo_data),
        .i_tx_fifo_space         (i_tx_fifo_space),
        .o_request               (o_request),
        .o_write                 (o_write),
        .i_busy                  (i_busy),
        .i_ack                   (i_ack),
        .o_bank                  (o_bank),
        .o_address               (o_address),
        .i_data                  (i_data),
        .o_data                  (o_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] d;
    } mem_t;

    mem_t        mq[$];
    logic [31:0] exp_d[$];
    logic [27:0] exp_a[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int push_cnt = 0;
    int last_push_cyc = 0;
    int viol = 0;
    int max_out = 0;
    int lat = 2;
    bit cap_mode = 1'b0;
    int cap = 2;
    int cap_base = 0;
    logic [SW-1:0] space_fixed = 11'd512;
    int spur_req = 0;
    int spur_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: sample away from the edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (mq.size() + int'(i_ack) > max_out) max_out = mq.size() + int'(i_ack);
            if (o_request && !i_busy) begin
                acc_cnt++;
                mq.push_back('{cyc + lat, {4'hD, o_bank, o_address}});
                if (exp_a.size() == 0) begin
                    total++; bad++;
                    $display("FAIL req_unexpected: got %0h expected none", {o_bank, o_address});
                end else begin
                    check("req_addr", 64'({o_bank, o_address}), 64'(exp_a.pop_front()));
                end
            end
            if (o_tx_fifo_push) begin
                push_cnt++;
                last_push_cyc = cyc;
                if (i_tx_fifo_space == '0) viol++;
                if (exp_d.size() == 0) begin
                    total++; bad++;
                    $display("FAIL push_unexpected: got %0h expected none", o_tx_fifo_data);
                end else begin
                    check("push_data", 64'(o_tx_fifo_data), 64'(exp_d.pop_front()));
                end
            end
        end
    end

    // Memory and FIFO-space driver
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mq.delete();
            i_ack = 1'b0;
        end else if (spur_req != spur_done) begin
            i_ack = 1'b1;
            i_data = 32'hBAD0BAD0;
            spur_done++;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            i_ack = 1'b1;
            i_data = mq[0].d;
            mq.pop_front();
        end else begin
            i_ack = 1'b0;
        end
        i_tx_fifo_space = cap_mode ? SW'(cap - (push_cnt - cap_base)) : space_fixed;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic load_start(input logic [3:0] b, input logic [23:0] a, input logic [14:0] len);
        i_dma_bank = b;
        i_dma_address = a;
        i_dma_length = len;
        i_dma_load_bank_address = 1'b1;
        i_dma_load_length = 1'b1;
        tick();
        i_dma_load_bank_address = 1'b0;
        i_dma_load_length = 1'b0;
        check("left_loaded", 64'(o_dma_left), 64'(len));
        i_dma_start = 1'b1;
        tick();
        i_dma_start = 1'b0;
        check("busy_after_start", 64'(o_dma_busy), 64'd1);
    endtask

    task automatic expect_words(input logic [3:0] b, input logic [23:0] a, input int n);
        logic [23:0] ad;
        for (int i = 0; i < n; i++) begin
            ad = a + 24'(i);
            exp_a.push_back({b, ad});
            exp_d.push_back({4'hD, b, ad});
        end
    endtask

    task automatic wait_idle(input string nm, output int fall_cyc);
        int k;
        fall_cyc = -1;
        for (k = 0; k < 3000; k++) begin
            if (!o_dma_busy) break;
            tick();
        end
        if (o_dma_busy) begin
            total++; bad++;
            $display("FAIL %s_timeout: got busy=1 expected busy=0", nm);
        end else begin
            fall_cyc = cyc;
        end
    endtask

    initial begin
        int fc;
        int base;
        int pbase;
        int bcnt;
        bit junk;
        bit stopped;

        // Reset values
        #2;
        check("rst_busy", 64'(o_dma_busy), 64'd0);
        check("rst_err", 64'(o_dma_error), 64'd0);
        check("rst_push", 64'(o_tx_fifo_push), 64'd0);
        check("rst_req", 64'(o_request), 64'd0);
        check("rst_bank_addr", 64'({o_bank, o_address}), 64'd0);
        check("rst_left", 64'(o_dma_left), 64'd0);
        check("rst_data", 64'(o_tx_fifo_data), 64'd0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Basic 4-word read, latency 2
        lat = 2;
        exp_a.push_back({4'd2, 24'h000100});
        exp_a.push_back({4'd2, 24'h000101});
        exp_a.push_back({4'd2, 24'h000102});
        exp_a.push_back({4'd2, 24'h000103});
        exp_d.push_back(32'hD2000100);
        exp_d.push_back(32'hD2000101);
        exp_d.push_back(32'hD2000102);
        exp_d.push_back(32'hD2000103);
        pbase = push_cnt;
        load_start(4'd2, 24'h000100, 15'd4);
        check("t1_write", 64'(o_write), 64'd0);
        check("t1_odata", 64'(o_data), 64'd0);
        wait_idle("t1", fc);
        check("t1_pushes", 64'(push_cnt - pbase), 64'd4);
        check("t1_left", 64'(o_dma_left), 64'd0);
        check("t1_busy_fall", 64'(fc), 64'(last_push_cyc + 1));
        check("t1_pending", 64'(exp_d.size()), 64'd0);

        // Long latency: outstanding capped at MAX_INFLIGHT
        lat = 10;
        max_out = 0;
        pbase = push_cnt;
        expect_words(4'd5, 24'h002000, 16);
        load_start(4'd5, 24'h002000, 15'd16);
        wait_idle("t2", fc);
        check("t2_max_outstanding", 64'(max_out), 64'(MAXI));
        check("t2_pushes", 64'(push_cnt - pbase), 64'd16);
        check("t2_pending", 64'(exp_d.size()), 64'd0);

        // FIFO space limited to 2 then raised to 8
        lat = 2;
        cap_mode = 1'b1;
        cap = 2;
        cap_base = push_cnt;
        viol = 0;
        base = acc_cnt;
        pbase = push_cnt;
        expect_words(4'd1, 24'h000500, 6);
        tick();
        load_start(4'd1, 24'h000500, 15'd6);
        tick(30);
        check("t3_accepts_capped", 64'(acc_cnt - base), 64'd2);
        check("t3_pushes_capped", 64'(push_cnt - pbase), 64'd2);
        check("t3_still_busy", 64'(o_dma_busy), 64'd1);
        space_fixed = 11'd8;
        cap_mode = 1'b0;
        wait_idle("t3", fc);
        check("t3_pushes", 64'(push_cnt - pbase), 64'd6);
        check("t3_no_push_at_zero", 64'(viol), 64'd0);
        space_fixed = 11'd512;
        tick();

        // Address wrap, bank unchanged
        exp_a.push_back({4'd7, 24'hFFFFFE});
        exp_a.push_back({4'd7, 24'hFFFFFF});
        exp_a.push_back({4'd7, 24'h000000});
        exp_d.push_back(32'hD7FFFFFE);
        exp_d.push_back(32'hD7FFFFFF);
        exp_d.push_back(32'hD7000000);
        load_start(4'd7, 24'hFFFFFE, 15'd3);
        wait_idle("t4", fc);
        check("t4_bank_addr", 64'({o_bank, o_address}), 64'h7000001);
        check("t4_pending", 64'(exp_d.size()), 64'd0);

        // Zero length: busy exactly 2 cycles, no request
        base = acc_cnt;
        load_start(4'd7, 24'h000010, 15'd0);
        bcnt = 1;
        for (int i = 0; i < 10 && o_dma_busy; i++) begin
            tick();
            if (o_dma_busy) bcnt++;
        end
        check("t5_busy_cycles", 64'(bcnt), 64'd2);
        check("t5_no_request", 64'(acc_cnt - base), 64'd0);

        // Stop after 3 accepted; loads/start while busy ignored
        lat = 3;
        base = acc_cnt;
        pbase = push_cnt;
        expect_words(4'd3, 24'h000040, 3);
        load_start(4'd3, 24'h000040, 15'd10);
        junk = 1'b0;
        stopped = 1'b0;
        for (int i = 0; i < 50 && !stopped; i++) begin
            if (acc_cnt - base == 1 && !junk) begin
                junk = 1'b1;
                i_dma_bank = 4'hF;
                i_dma_address = 24'hABCDEF;
                i_dma_length = 15'd99;
                i_dma_load_bank_address = 1'b1;
                i_dma_load_length = 1'b1;
                i_dma_start = 1'b1;
                tick();
                i_dma_load_bank_address = 1'b0;
                i_dma_load_length = 1'b0;
                i_dma_start = 1'b0;
            end else if (acc_cnt - base >= 3) begin
                i_busy = 1'b1;
                i_dma_stop = 1'b1;
                tick();
                i_busy = 1'b0;
                i_dma_stop = 1'b0;
                stopped = 1'b1;
            end else begin
                tick();
            end
        end
        wait_idle("t6", fc);
        check("t6_accepts", 64'(acc_cnt - base), 64'd3);
        check("t6_pushes", 64'(push_cnt - pbase), 64'd3);
        check("t6_left", 64'(o_dma_left), 64'd7);
        check("t6_bank_addr", 64'({o_bank, o_address}), 64'h3000043);
        check("t6_busy_fall", 64'(fc), 64'(last_push_cyc + 1));

        // Stop or start+stop in idle has no effect
        i_dma_start = 1'b1;
        i_dma_stop = 1'b1;
        tick();
        i_dma_start = 1'b0;
        i_dma_stop = 1'b0;
        check("idle_start_stop", 64'(o_dma_busy), 64'd0);

        // Spurious ack in idle
        lat = 2;
        pbase = push_cnt;
        spur_req++;
        tick(3);
        check("t7_err_set", 64'(o_dma_error), 64'd1);
        check("t7_no_push", 64'(push_cnt - pbase), 64'd0);
        expect_words(4'd6, 24'h000200, 1);
        load_start(4'd6, 24'h000200, 15'd1);
        check("t7_err_cleared", 64'(o_dma_error), 64'd0);
        wait_idle("t7", fc);

        // Asynchronous reset mid-transfer
        expect_words(4'd4, 24'h000010, 8);
        load_start(4'd4, 24'h000010, 15'd8);
        tick(4);
        rst_n = 1'b0;
        #1;
        check("t8_busy", 64'(o_dma_busy), 64'd0);
        check("t8_push", 64'(o_tx_fifo_push), 64'd0);
        check("t8_req", 64'(o_request), 64'd0);
        check("t8_bank_addr_left", 64'({o_bank, o_address, o_dma_left}), 64'd0);
        check("t8_data", 64'(o_tx_fifo_data), 64'd0);
        exp_a.delete();
        exp_d.delete();
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("t8_idle_after", 64'(o_dma_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
